// File: rtl/octave_scheduler.sv
// octave_scheduler: walks the image buffer octave by octave and feeds every
// pixel through the shared downsampler. After each octave it waits for the
// downsampler FIFO to empty, halves the dimensions and continues, until the
// requested octave count or the minimum image size is reached.
module octave_scheduler #(
    parameter int IMG_W   = 1600,
    parameter int IMG_H   = 1200,
    parameter int NUM_OCT = 4,
    parameter int ADDR_W  = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        cfg_octaves,
    output logic              busy,
    output logic              done,
    output logic [2:0]        octave,
    output logic [10:0]       oct_w,
    output logic [10:0]       oct_h,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        ds_din,
    output logic              ds_valid,
    input  logic              ds_ready,
    input  logic              ds_empty
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_PUSH  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [10:0] IMG_W_C   = 11'(IMG_W);
    localparam logic [10:0] IMG_H_C   = 11'(IMG_H);
    localparam logic [2:0]  NUM_OCT_C = 3'(NUM_OCT);

    logic [2:0]        state_q,  state_d;
    logic [2:0]        n_oct_q,  n_oct_d;
    logic [2:0]        octave_q, octave_d;
    logic [10:0]       oct_w_q,  oct_w_d;
    logic [10:0]       oct_h_q,  oct_h_d;
    logic [10:0]       col_q,    col_d;
    logic [10:0]       row_q,    row_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [7:0]        din_q,    din_d;
    logic              req_q,    req_d;
    logic              valid_q,  valid_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic        last_col;
    logic        last_row;
    logic [2:0]  octave_inc;
    logic [10:0] half_w;
    logic [10:0] half_h;

    assign last_col   = (col_q == oct_w_q - 11'd1);
    assign last_row   = (row_q == oct_h_q - 11'd1);
    assign octave_inc = octave_q + 3'd1;
    assign half_w     = oct_w_q >> 1;
    assign half_h     = oct_h_q >> 1;

    // Next-state logic; req/valid/done are recomputed every cycle so they are
    // high only in the state that owns them, which keeps req and valid exclusive.
    always_comb begin
        state_d  = state_q;
        n_oct_d  = n_oct_q;
        octave_d = octave_q;
        oct_w_d  = oct_w_q;
        oct_h_d  = oct_h_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        din_d    = din_q;
        busy_d   = busy_q;
        req_d    = 1'b0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_octaves == 3'd0)
                        n_oct_d = 3'd1;
                    else if (cfg_octaves > NUM_OCT_C)
                        n_oct_d = NUM_OCT_C;
                    else
                        n_oct_d = cfg_octaves;
                    octave_d = 3'd0;
                    oct_w_d  = IMG_W_C;
                    oct_h_d  = IMG_H_C;
                    addr_d   = '0;
                    col_d    = 11'd0;
                    row_d    = 11'd0;
                    busy_d   = 1'b1;
                    req_d    = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_rd_ack) begin
                    din_d   = mem_rd_data;
                    valid_d = 1'b1;
                    state_d = S_PUSH;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_PUSH: begin
                if (ds_ready) begin
                    if (last_col && last_row) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                        if (last_col) begin
                            col_d = 11'd0;
                            row_d = row_q + 11'd1;
                        end else begin
                            col_d = col_q + 11'd1;
                        end
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // The step past the last pixel makes the next octave's base
                // contiguous with the image just read.
                if (ds_empty) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                octave_d = octave_inc;
                oct_w_d  = half_w;
                oct_h_d  = half_h;
                col_d    = 11'd0;
                row_d    = 11'd0;
                if ((octave_inc == n_oct_q) || (half_w < 11'd2) || (half_h < 11'd2)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any pass without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            n_oct_q  <= 3'd1;
            octave_q <= 3'd0;
            oct_w_q  <= IMG_W_C;
            oct_h_q  <= IMG_H_C;
            col_q    <= 11'd0;
            row_q    <= 11'd0;
            addr_q   <= '0;
            din_q    <= 8'd0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_oct_q  <= n_oct_d;
            octave_q <= octave_d;
            oct_w_q  <= oct_w_d;
            oct_h_q  <= oct_h_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign octave      = octave_q;
    assign oct_w       = oct_w_q;
    assign oct_h       = oct_h_q;
    assign mem_rd_req  = req_q;
    assign mem_rd_addr = addr_q;
    assign ds_din      = din_q;
    assign ds_valid    = valid_q;

endmodule

// File: tb/tb_octave_scheduler.sv
// tb_octave_scheduler: drives an 8x4 pyramid pass through the scheduler with a
// behavioural image-buffer / downsampler environment and checks every pixel
// transfer against a list of expected reads built from the octave rules.
`timescale 1ns/1ps
module tb_octave_scheduler;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int NUM_OCT = 4;
    localparam int ADDR_W  = 21;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        cfg_octaves = 3'd0;
    logic              busy, done;
    logic [2:0]        octave;
    logic [10:0]       oct_w, oct_h;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack = 1'b0;
    logic [7:0]        mem_rd_data = 8'd0;
    logic [7:0]        ds_din;
    logic              ds_valid;
    logic              ds_ready = 1'b1;
    logic              ds_empty = 1'b1;

    always #5 clk = ~clk;

    octave_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_OCT(NUM_OCT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_octaves(cfg_octaves),
        .busy(busy), .done(done), .octave(octave), .oct_w(oct_w), .oct_h(oct_h),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .ds_din(ds_din), .ds_valid(ds_valid),
        .ds_ready(ds_ready), .ds_empty(ds_empty)
    );

    typedef struct {
        int addr; int data; int oct; int w; int h; bit first; bit last;
    } px_t;

    typedef struct {
        int cfg; int amax; bit rrand; int blk; int hold; bit fast; int px; int oct;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // environment controls (owned by the main sequence)
    int  drv_mode = 0;
    int  ack_max = 0;
    bit  rdy_rand = 0;
    int  blk_at = -1;
    int  hold = 0;
    bit  fast = 0;
    bit  rnd_mode = 0;
    bit  mon_en = 0;
    int  pass_no = 0;
    int  xfer_base = 0;
    px_t exp_a[$];

    // monitor-owned
    int  cyc = 0;
    int  xfer_cnt = 0;
    int  done_cnt = 0;
    int  stall_cnt = 0;
    int  drain_arm = 0;
    int  prev_xfer_cyc = 0;
    bit  in_drain = 0;
    int  mon_idx;
    px_t mon_e;
    logic [ADDR_W-1:0] rd_addr_cap = '0;
    logic p_req = 0, p_ack = 0, p_valid = 0, p_ready = 0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [7:0] p_din = 8'd0;

    // driver-owned
    int ack_wait = 0;
    int blk_left = 0;
    int blk_done_pass = -1;
    int drain_seen = 0;
    int drain_left = 0;

    function automatic logic [7:0] mem_f(input logic [ADDR_W-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd13) ^ 8'hA5 ^ a[15:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, mem_rd_req, 0);
        chk({tag, "_valid"}, ds_valid, 0);
        chk({tag, "_addr"}, mem_rd_addr, 0);
        chk({tag, "_din"}, ds_din, 0);
        chk({tag, "_octave"}, octave, 0);
        chk({tag, "_oct_w"}, oct_w, IMG_W);
        chk({tag, "_oct_h"}, oct_h, IMG_H);
    endtask

    // Reference: every octave is a w*h block of consecutive addresses, the
    // next block follows directly, and dimensions halve until the octave
    // budget is spent or either side would drop below 2.
    task automatic build_model(input int cfg, output int n_px, output int final_oct);
        int n, w, h, base, o;
        n = (cfg == 0) ? 1 : ((cfg > NUM_OCT) ? NUM_OCT : cfg);
        w = IMG_W; h = IMG_H; base = 0; o = 0; n_px = 0;
        exp_a.delete();
        forever begin
            for (int p = 0; p < w * h; p++) begin
                px_t e;
                e.addr = base + p;
                e.data = int'(mem_f(ADDR_W'(base + p)));
                e.oct = o; e.w = w; e.h = h;
                e.first = (p == 0); e.last = (p == w * h - 1);
                exp_a.push_back(e);
                n_px++;
            end
            base = base + w * h;
            o = o + 1; w = w / 2; h = h / 2;
            if (o == n || w < 2 || h < 2) break;
        end
        final_oct = o;
    endtask

    // Image buffer and downsampler stand-ins, updated just after each edge.
    always @(posedge clk) begin
        #2;
        if (drv_mode == 0) begin
            mem_rd_ack  = 1'($urandom_range(0, 1));
            mem_rd_data = 8'($urandom);
            ds_ready    = 1'($urandom_range(0, 1));
            ds_empty    = 1'($urandom_range(0, 1));
        end else begin
            if (mem_rd_req) begin
                if (ack_wait == 0) begin
                    mem_rd_ack  = 1'b1;
                    mem_rd_data = mem_f(mem_rd_addr);
                end else begin
                    ack_wait--;
                    mem_rd_ack  = 1'b0;
                    mem_rd_data = 8'($urandom);
                end
            end else begin
                ack_wait    = $urandom_range(0, ack_max);
                mem_rd_ack  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rd_data = 8'($urandom);
            end
            if (blk_left > 0) begin
                ds_ready = 1'b0;
                blk_left--;
            end else if (blk_at >= 0 && blk_done_pass != pass_no && (xfer_cnt - xfer_base) == blk_at) begin
                ds_ready = 1'b0;
                blk_left = 4;
                blk_done_pass = pass_no;
            end else begin
                ds_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (drain_arm != drain_seen) begin
                drain_seen = drain_arm;
                drain_left = hold;
            end
            if (drain_left > 0) begin
                ds_empty = 1'b0;
                drain_left--;
            end else begin
                ds_empty = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Protocol checks and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("req_valid_excl", 32'(mem_rd_req & ds_valid), 0);
            if (p_req && !p_ack) begin
                chk("req_held", mem_rd_req, 1);
                chk("addr_stable", mem_rd_addr, p_addr);
            end
            if (p_valid && !p_ready) begin
                chk("valid_held", ds_valid, 1);
                chk("din_stable", ds_din, p_din);
            end
            if (ds_valid && !ds_ready) stall_cnt++;
            if (in_drain && hold > 0 && !rnd_mode && !ds_empty)
                chk("drain_no_req", mem_rd_req, 0);
            if (mem_rd_req || done) in_drain = 0;
            if (mem_rd_req && mem_rd_ack) rd_addr_cap = mem_rd_addr;
            if (ds_valid && ds_ready) begin
                mon_idx = xfer_cnt - xfer_base;
                if (mon_idx >= exp_a.size()) begin
                    chk("xfer_overrun", mon_idx, exp_a.size());
                end else begin
                    mon_e = exp_a[mon_idx];
                    chk("rd_addr", rd_addr_cap, mon_e.addr);
                    chk("ds_din", ds_din, mon_e.data);
                    chk("octave", octave, mon_e.oct);
                    chk("oct_w", oct_w, mon_e.w);
                    chk("oct_h", oct_h, mon_e.h);
                    if (fast && !mon_e.first) chk("pixel_period", cyc - prev_xfer_cyc, 2);
                    if (mon_e.last) begin
                        in_drain = 1;
                        drain_arm++;
                    end
                end
                prev_xfer_cyc = cyc;
                xfer_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1);
            end
        end
        p_req = mem_rd_req; p_ack = mem_rd_ack; p_addr = mem_rd_addr;
        p_valid = ds_valid; p_ready = ds_ready; p_din = ds_din;
    end

    task automatic start_pass(input int cfg, input int amax, input bit rrand, input int bat,
                              input int hld, input bit fst, input bit rnd);
        int npx, fo;
        build_model(cfg, npx, fo);
        ack_max = amax; rdy_rand = rrand; blk_at = bat; hold = hld;
        fast = fst; rnd_mode = rnd; pass_no++;
        xfer_base = xfer_cnt;
        mon_en = 1;
        @(posedge clk); #1;
        start = 1'b1; cfg_octaves = 3'(cfg);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int cfg, input int amax, input bit rrand,
                            input int bat, input int hld, input bit fst, input bit rnd,
                            input int exp_px, input int exp_oct);
        int done_base, stall_base, waited;
        bit got;
        done_base = done_cnt;
        stall_base = stall_cnt;
        start_pass(cfg, amax, rrand, bat, hld, fst, rnd);
        @(negedge clk); #1;
        chk({tag, "_start_req"}, mem_rd_req, 1);
        chk({tag, "_start_busy"}, busy, 1);
        got = 0;
        for (waited = 0; waited < 3000 && !got; waited++) begin
            @(negedge clk); #1;
            start = (rnd && waited == 20);
            if (start) cfg_octaves = 3'($urandom);
            if (done_cnt != done_base) got = 1;
        end
        start = 1'b0;
        if (!got) chk({tag, "_timeout"}, waited, 0);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
        chk({tag, "_xfers"}, xfer_cnt - xfer_base, exp_px);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_final_octave"}, octave, exp_oct);
        if (bat >= 0) chk({tag, "_bp_stalled"}, 32'((stall_cnt - stall_base) >= 1), 1);
        $display("pass %s cfg=%0d xfers=%0d octave=%0d waited=%0d", tag, cfg,
                 xfer_cnt - xfer_base, octave, waited);
    endtask

    initial begin
        vec_t tbl[6];
        int npx, fo, waited;

        // reset with random inputs
        #3 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom_range(0, 1));
            cfg_octaves = 3'($urandom);
            @(negedge clk);
            chk_reset("rst_hold");
        end
        start = 1'b0;
        drv_mode = 1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_no_req", mem_rd_req, 0);
            chk("idle_busy", busy, 0);
        end

        // {cfg, ack_max, ready_random, block_at, drain_hold, fast, pixels, final octave}
        // An 8x4 image yields octaves 8x4 and 4x2; a 2x1 octave is never started.
        tbl[0] = '{1, 0, 0, -1, 0,  1, 32, 1};   // single octave, full rate
        tbl[1] = '{3, 0, 0, -1, 0,  1, 40, 2};   // stops on size after two octaves
        tbl[2] = '{0, 0, 0, -1, 0,  1, 32, 1};   // zero means one octave
        tbl[3] = '{7, 0, 0, -1, 0,  1, 40, 2};   // clamped, then size limit
        tbl[4] = '{2, 3, 0, 3,  0,  0, 40, 2};   // ready dropped mid-row, slow acks
        tbl[5] = '{2, 0, 0, -1, 10, 1, 40, 2};   // FIFO stays non-empty in drain
        for (int i = 0; i < 6; i++)
            run_pass($sformatf("vec%0d", i), tbl[i].cfg, tbl[i].amax, tbl[i].rrand,
                     tbl[i].blk, tbl[i].hold, tbl[i].fast, 0, tbl[i].px, tbl[i].oct);

        // randomized traffic against the reference
        for (int i = 0; i < 8; i++) begin
            int c;
            c = $urandom_range(0, 7);
            build_model(c, npx, fo);
            run_pass($sformatf("rnd%0d", i), c, 3, 1, -1, 0, 0, 1, npx, fo);
        end

        // abort in the middle of octave 1
        start_pass(3, 0, 0, -1, 0, 1, 0);
        for (waited = 0; waited < 500 && (xfer_cnt - xfer_base) < 36; waited++) @(negedge clk);
        if (waited >= 500) chk("abort_reach_timeout", waited, 0);
        chk("abort_in_oct1", octave, 1);
        mon_en = 0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_reset("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_held_req", mem_rd_req, 0);
        end
        rst = 1'b1;
        $display("abort applied after %0d transfers", xfer_cnt - xfer_base);
        run_pass("after_abort", 1, 0, 0, -1, 0, 1, 0, 32, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
